// File: rtl/button_capture_if.sv
// ============================================================================
// Module      : button_capture_if
// Description : Processor read port of the button capture peripheral.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface button_capture_if;
    logic        read_en;
    logic [31:0] data_out;

    // Processor side drives the read strobe and samples the event word.
    modport master (
        output read_en,
        input  data_out
    );

    // Peripheral side presents the event word and consumes the read strobe.
    modport slave (
        input  read_en,
        output data_out
    );
endinterface

`default_nettype wire

// File: rtl/button_capture.sv
// ============================================================================
// Module      : button_capture
// Description : Synchronizes and debounces four push-buttons, queues each
//               debounced press as a colour event, read-to-clear word port.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module button_capture #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               red_button,
    input  logic               blue_button,
    input  logic               green_button,
    input  logic               yellow_button,
    button_capture_if.slave    cpu
);

    localparam int                NUM_BTN  = 4;
    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam int                PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PTR_W:0]    CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    // Bit index equals the colour code: red, blue, green, yellow.
    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] stable;
    assign raw = {yellow_button, green_button, blue_button, red_button};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_button
        logic             meta_q;
        logic             sync_q;
        logic             stable_q;
        logic             stable_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;

        // Level is accepted only after DEBOUNCE_CYCLES consecutive mismatches.
        always_comb begin
            stable_d = stable_q;
            cnt_d    = cnt_q;
            if (sync_q == stable_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                stable_d = ~stable_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                meta_q   <= 1'b0;
                sync_q   <= 1'b0;
                stable_q <= 1'b0;
                cnt_q    <= '0;
            end else begin
                meta_q   <= raw[i];
                sync_q   <= meta_q;
                stable_q <= stable_d;
                cnt_q    <= cnt_d;
            end
        end

        assign stable[i] = stable_q;
    end

    // ------------------------------------------------------------------
    // Press detect and pending bits
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] stable_dly_q;
    logic [NUM_BTN-1:0] pending_q;
    logic [NUM_BTN-1:0] pending_d;
    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] grant_oh;
    logic [1:0]         push_colour;

    assign rise = stable & ~stable_dly_q;

    // Fixed priority: lowest index (red) wins.
    always_comb begin
        grant_oh    = '0;
        push_colour = 2'd0;
        if (pending_q[0]) begin
            grant_oh    = 4'b0001;
            push_colour = 2'd0;
        end else if (pending_q[1]) begin
            grant_oh    = 4'b0010;
            push_colour = 2'd1;
        end else if (pending_q[2]) begin
            grant_oh    = 4'b0100;
            push_colour = 2'd2;
        end else if (pending_q[3]) begin
            grant_oh    = 4'b1000;
            push_colour = 2'd3;
        end
    end

    // A granted bit is cleared whether or not the FIFO accepts the event.
    assign pending_d = (pending_q & ~grant_oh) | rise;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stable_dly_q <= '0;
            pending_q    <= '0;
        end else begin
            stable_dly_q <= stable;
            pending_q    <= pending_d;
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    logic [1:0]     mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0] count_q;
    logic [PTR_W:0] count_d;
    logic           ovf_q;
    logic           ovf_d;
    logic           push;
    logic           pop;
    logic           full;
    logic           do_write;
    logic           drop;

    assign push     = |pending_q;
    assign pop      = cpu.read_en && (count_q != '0);
    assign full     = (count_q == CNT_FULL);
    // When full, a same-edge pop frees the head slot that wr_ptr points at.
    assign do_write = push && (!full || pop);
    assign drop     = push && full && !pop;

    always_comb begin
        count_d = count_q;
        if (do_write && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !do_write) begin
            count_d = count_q - 1'b1;
        end
    end

    // Any read clears overflow, but a drop on the same edge keeps it set.
    assign ovf_d = drop | (ovf_q & ~cpu.read_en);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                mem_q[k] <= 2'd0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (do_write) begin
                mem_q[wr_ptr_q] <= push_colour;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Read word
    // ------------------------------------------------------------------
    logic       valid;
    logic [1:0] head_colour;

    assign valid       = (count_q != '0);
    assign head_colour = valid ? mem_q[rd_ptr_q] : 2'd0;

    assign cpu.data_out = {28'd0, ovf_q, head_colour, valid};

endmodule

`default_nettype wire

// File: tb/tb_button_capture.sv
// ============================================================================
// Module      : tb_button_capture
// Description : Randomized and directed bench for button_capture against a
//               window-based behavioural model with an event queue.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_button_capture;

    localparam int N     = 4;
    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] btn   = 4'b0;

    button_capture_if bus ();

    button_capture #(
        .DEBOUNCE_CYCLES (N),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .red_button    (btn[0]),
        .blue_button   (btn[1]),
        .green_button  (btn[2]),
        .yellow_button (btn[3]),
        .cpu           (bus)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 32'h%08h expected 32'h%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a level is accepted once the last N synchronized
    // samples all disagree with it; presses become queued colour events.
    // ------------------------------------------------------------------
    logic [3:0]   m_meta, m_sync, m_stable, m_prev, m_pend;
    logic [N-1:0] m_win [4];
    int           m_fill [4];
    int           m_q [$];
    logic         m_ovf;

    task automatic model_reset();
        m_meta = '0; m_sync = '0; m_stable = '0; m_prev = '0; m_pend = '0;
        for (int i = 0; i < 4; i++) begin
            m_win[i]  = '0;
            m_fill[i] = 0;
        end
        m_q.delete();
        m_ovf = 1'b0;
    endtask

    function automatic logic [31:0] model_word();
        logic [31:0] w;
        w = '0;
        if (m_q.size() > 0) begin
            w[0]   = 1'b1;
            w[2:1] = 2'(m_q[0]);
        end
        w[3] = m_ovf;
        return w;
    endfunction

    task automatic model_step(input logic [3:0] b, input logic rd);
        int   grant;
        logic pop;
        logic full;
        grant = -1;
        for (int i = 0; i < 4; i++) begin
            if (m_pend[i] && grant < 0) grant = i;
        end
        pop  = rd && (m_q.size() > 0);
        full = (m_q.size() == DEPTH);
        if (rd) m_ovf = 1'b0;
        if (pop) void'(m_q.pop_front());
        if (grant >= 0) begin
            if (full && !pop) m_ovf = 1'b1;
            else m_q.push_back(grant);
            m_pend[grant] = 1'b0;
        end
        m_pend = m_pend | (m_stable & ~m_prev);
        m_prev = m_stable;
        for (int i = 0; i < 4; i++) begin
            m_win[i] = {m_win[i][N-2:0], m_sync[i]};
            if (m_fill[i] < N) m_fill[i]++;
            if (m_fill[i] == N && m_win[i] == {N{~m_stable[i]}}) m_stable[i] = ~m_stable[i];
        end
        m_sync = m_meta;
        m_meta = b;
    endtask

    // ------------------------------------------------------------------
    // Stimulus helpers (entered and left at posedge + 1)
    // ------------------------------------------------------------------
    task automatic tick(input logic [3:0] b, input logic rd);
        btn         = b;
        bus.read_en = rd;
        if (rd) begin
            #1 check("read_same_cycle", bus.data_out, model_word());
        end
        @(posedge clock);
        model_step(b, rd);
        #1 check("cycle", bus.data_out, model_word());
    endtask

    task automatic press(input logic [3:0] m, input int hold, input int total, input int read_at);
        for (int i = 0; i < total; i++) tick((i < hold) ? m : 4'b0, i == read_at);
    endtask

    task automatic do_reset();
        bus.read_en = 1'b0;
        #2 reset = 1'b1;
        #1 check("reset_async", bus.data_out, 32'h0);
        model_reset();
        @(posedge clock);
        #1 check("reset_hold", bus.data_out, 32'h0);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.read_en = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1 check("reset_state", bus.data_out, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        // Single blue press: event appears on the 8th edge.
        for (int i = 0; i < 12; i++) begin
            tick(4'b0010, 1'b0);
            if (i == 6) check("press_edge7", bus.data_out, 32'h0);
            if (i == 7) check("press_edge8", bus.data_out, 32'h3);
        end
        tick(4'b0010, 1'b1);
        check("press_read", bus.data_out, 32'h0);
        press(4'b0000, 16, 16, -1);
        check("press_release", bus.data_out, 32'h0);

        // Glitches shorter than the debounce window.
        press(4'b0100, 3, 13, -1);
        press(4'b1000, 1, 11, -1);
        check("glitch", bus.data_out, 32'h0);

        // Red and yellow together: red queued first.
        for (int i = 0; i < 12; i++) begin
            tick(4'b1001, 1'b0);
            if (i == 7) check("simul_edge8", bus.data_out, 32'h1);
        end
        tick(4'b0000, 1'b1);
        check("simul_read1", bus.data_out, 32'h7);
        tick(4'b0000, 1'b1);
        check("simul_read2", bus.data_out, 32'h0);
        press(4'b0000, 0, 12, -1);

        // Five presses without reads overflow a 4-deep queue.
        press(4'b0001, 6, 16, -1);
        press(4'b0010, 6, 16, -1);
        press(4'b0100, 6, 16, -1);
        press(4'b1000, 6, 16, -1);
        press(4'b0001, 6, 16, -1);
        check("ovf_word", bus.data_out, 32'h9);
        tick(4'b0000, 1'b1); check("ovf_read1", bus.data_out, 32'h3);
        tick(4'b0000, 1'b1); check("ovf_read2", bus.data_out, 32'h5);
        tick(4'b0000, 1'b1); check("ovf_read3", bus.data_out, 32'h7);
        tick(4'b0000, 1'b1); check("ovf_read4", bus.data_out, 32'h0);

        // Push on the same edge as a read while full: no overflow.
        press(4'b0001, 6, 16, -1);
        press(4'b0010, 6, 16, -1);
        press(4'b0100, 6, 16, -1);
        press(4'b1000, 6, 16, -1);
        press(4'b0010, 6, 16, 7);
        check("full_pop_no_ovf", bus.data_out, 32'h3);
        repeat (4) tick(4'b0000, 1'b1);
        check("full_pop_drain", bus.data_out, 32'h0);

        // Reset while two entries queued and blue mid-debounce.
        press(4'b0001, 6, 16, -1);
        press(4'b0100, 6, 14, -1);
        press(4'b0010, 3, 3, -1);
        do_reset();
        for (int i = 0; i < 12; i++) begin
            tick(4'b0010, 1'b0);
            if (i == 6) check("rst_mid_edge7", bus.data_out, 32'h0);
            if (i == 7) check("rst_mid_edge8", bus.data_out, 32'h3);
        end
        press(4'b0000, 0, 12, -1);
        tick(4'b0000, 1'b1);

        // Randomized traffic with occasional asynchronous resets.
        for (int it = 0; it < 400; it++) begin
            logic [3:0] m;
            int         hold;
            int         rd_div;
            m      = 4'($urandom_range(0, 15));
            hold   = $urandom_range(1, 10);
            rd_div = (it < 200) ? 8 : 3;
            for (int c = 0; c < hold; c++) tick(m, $urandom_range(0, rd_div - 1) == 0);
            if ($urandom_range(0, 39) == 0) do_reset();
        end

        // Reset from a random state, then idle.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            tick(4'b0000, 1'b0);
            check("reset_idle", bus.data_out, 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/button_capture.md
# button_capture

Memory-mapped input peripheral behind the processor's button-read address, data memory word 7. It synchronizes and debounces the four raw push-buttons and turns each debounced press into a colour event. Events are queued in a small FIFO and presented to the processor as a read-to-clear word. The colour encoding matches the LED flash register at address 6, so a returned word can be stored there unchanged to light the matching LED.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: cycles an input must hold a new level before it is accepted (10 ms at 50 MHz). Must be ≥ 2.
- `FIFO_DEPTH`, default 4: number of queued press events. Must be a power of 2, ≥ 2.

Ports (one clock; reset is asynchronous and active-high):
- `clock` in 1: 50 MHz system clock.
- `reset` in 1: asynchronous, active-high; clears all state.
- `red_button` in 1: raw, asynchronous, active-high.
- `blue_button` in 1: raw, asynchronous, active-high.
- `green_button` in 1: raw, asynchronous, active-high.
- `yellow_button` in 1: raw, asynchronous, active-high.
- `read_en` in 1: high for one cycle when the processor loads address 7. Pops the FIFO head.
- `data_out` out 32: event word, combinational from FIFO head and flags.

## Operation
- Colour codes: red = 00, blue = 01, green = 10, yellow = 11.
- Word format:
  - `data_out[0]` = valid (FIFO non-empty).
  - `data_out[2:1]` = head colour.
  - `data_out[3]` = overflow flag (sticky).
  - `data_out[31:4]` = 0.
  - When empty, `data_out[2:0]` = 0.
- Per-button pipeline:
  - Two-flop synchronizer produces `sync`.
  - Debouncer holds `stable` and a counter of width clog2(DEBOUNCE_CYCLES).
  - Counter clears on any edge where `sync == stable`.
  - Otherwise: if the counter equals DEBOUNCE_CYCLES-1, toggle `stable` and clear the counter; else increment the counter.
- Press detect:
  - `stable_d` is a registered copy of `stable`.
  - A rising `stable & ~stable_d` sets that colour's pending bit on the next edge.
  - Releases generate nothing.
- Arbiter:
  - Each cycle, the highest-priority pending bit is pushed into the FIFO and cleared. Priority order: red > blue > green > yellow.
  - At most one push per cycle.
  - If a pending bit is already set when a new press arrives, the presses merge into one event.
- FIFO: circular buffer, read and write pointers wrap modulo FIFO_DEPTH, count 0..FIFO_DEPTH.
  - Pop: `read_en` high and count > 0 → head advances on that edge.
  - `read_en` while empty → no state change except clearing the overflow flag.
  - Push while full with a pop on the same edge → both happen; count unchanged; no overflow.
  - Push while full without a pop → event dropped, its pending bit is still cleared, overflow is set.
  - Overflow clears on any edge where `read_en` is high. If a drop occurs on that same edge, the set wins.
- Reset (asynchronous, any time, including mid-debounce or mid-queue):
  - Clears synchronizers, `stable`, `stable_d`, counters, pending bits, pointers, count and overflow.
  - `data_out` reads 0 immediately.
  - A button held across reset release is seen as a new press after the full debounce latency.

## Timing
- Press latency, with N = DEBOUNCE_CYCLES and edge 1 the first edge sampling the input high:
  - `sync` goes high after edge 2.
  - `stable` goes high at edge N+2.
  - Pending bit sets at edge N+3.
  - FIFO push at edge N+4.
  - `data_out` is valid after edge N+4, so total latency is N+4 edges.
- An input that is high for fewer than N consecutive sampled cycles after synchronization produces no event.
- Read side:
  - `data_out` is combinational from registered state, so the value is valid in the same cycle `read_en` is asserted.
  - The next entry, or 0, appears after that edge.
- Presses that are pending at the same time are queued in consecutive cycles in priority order.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and FIFO_DEPTH=4.
- **Reset:** assert `reset` between edges with a random internal state → `data_out` = 0 immediately; it stays 0 for 20 cycles with all buttons low.
- **Single press:** blue held high for 12 cycles → `data_out` = 0 until edge 8, then 32'h3. Pulse `read_en` → 32'h0 after the edge. Release → no new event.
- **Glitch rejection:** green high for 3 cycles, then low; also a 1-cycle yellow spike → `data_out` stays 0 throughout.
- **Simultaneous press:** red and yellow rise on the same edge → 32'h1 at edge 8. Read → 32'h7. Read → 32'h0.
- **Overflow:** five separate presses (red, blue, green, yellow, red) with no reads → `data_out` = 32'h9. Reads then return 32'h3, 32'h5, 32'h7, 32'h0. Also: a push on the same edge as a read while full → no overflow set.
- **Reset mid-operation:** reset pulsed while 2 entries are queued and blue is mid-debounce, with blue held → `data_out` = 0. Blue then reappears as 32'h3 exactly 8 edges after reset deasserts.
